note_dac_driver: RTL and testbench

Downstream consumer of the music box's `box_freq` / `box_left_freq` tone outputs. Converts the two per-channel tone frequencies (Hz) into square-wave PCM samples with selectable volume. Serialises them as 16-bit two's-complement stereo on an I2S-format four-wire DAC link (MCLK, LRCK, SCK, SDIN). One instance per board, between the music box and the audio DAC pins.

---
 rtl/note_dac_driver.sv | 84 ++++++++
 tb/tb_note_dac_driver.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/note_dac_driver.sv
// note_dac_driver: square-wave tones to I2S stereo DAC link; optional mute input under NOTE_DAC_MUTE_EN
module note_dac_driver #(
    parameter int CLK_FREQ = 100_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] left_freq,
    input  logic [31:0] right_freq,
    input  logic [2:0]  volume,
`ifdef NOTE_DAC_MUTE_EN
    input  logic        mute,
`endif
    output logic        mclk,
    output logic        lrck,
    output logic        sck,
    output logic        sdin
);
    localparam logic [32:0] MOD = 33'(CLK_FREQ);
    logic [9:0]  cnt;
    logic [31:0] frame;
    logic [15:0] amp;
    logic [31:0] freq [2];
    logic [15:0] smp [2];
    logic [5:0]  nh;
    logic [3:0]  idx;
    logic [15:0] word;
    logic        bit_nxt;
    logic        latch_zero;
    assign mclk = cnt[1];
    assign sck  = cnt[3];
    assign lrck = cnt[9];
    assign freq[0] = left_freq;
    assign freq[1] = right_freq;
    assign amp = 16'd512 << (volume > 3'd5 ? 3'd5 : volume);
`ifdef NOTE_DAC_MUTE_EN
    assign latch_zero = mute;
`else
    assign latch_zero = 1'b0;
`endif
    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic [31:0] acc;
        logic        sq;
        logic [32:0] step;
        logic [32:0] sum;
        logic        off;
        assign step = {freq[c], 1'b0};
        assign sum = {1'b0, acc} + step;
        assign off = freq[c] == 32'd0 || step >= MOD;
        assign smp[c] = off ? 16'd0 : sq ? amp : -amp;
        // phase accumulator: sq toggles each time 2*freq accumulates past CLK_FREQ
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                acc <= '0;
                sq  <= 1'b0;
            end else if (off) begin
                acc <= '0;
                sq  <= 1'b0;
            end else if (sum >= MOD) begin
                acc <= 32'(sum - MOD);
                sq  <= ~sq;
            end else begin
                acc <= sum[31:0];
            end
        end
    end
    assign nh = cnt[9:4] + 6'd1;
    assign idx = 4'(5'd16 - nh[4:0]);
    assign word = nh[5] ? frame[15:0] : frame[31:16];
    assign bit_nxt = (nh[4:0] != 5'd0 && nh[4:0] <= 5'd16) ? word[idx] : 1'b0;
    // frame counter, frame latch at cnt=1023, sdin launched one clk before each new sck slot
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            frame <= '0;
            sdin  <= 1'b0;
        end else begin
            cnt <= cnt + 10'd1;
            if (cnt == 10'd1023)
                frame <= latch_zero ? 32'd0 : {smp[0], smp[1]};
            if (cnt[3:0] == 4'hf)
                sdin <= bit_nxt;
        end
    end
endmodule

// File: tb/tb_note_dac_driver.sv
// tb_note_dac_driver: scoreboard bench; model predicts each latched frame, monitor deserialises sdin
module tb_note_dac_driver;
    localparam longint CLK = 100_000_000;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] left_freq;
    logic [31:0] right_freq;
    logic [2:0]  volume;
`ifdef NOTE_DAC_MUTE_EN
    logic        mute;
`endif
    logic        mclk;
    logic        lrck;
    logic        sck;
    logic        sdin;
    int checks = 0;
    int fails = 0;
    int frames_total = 0;
    logic [9:0]  mcnt;
    longint      s [2];
    logic [31:0] exp_q [$];
    logic [31:0] rx_l [$];
    logic [31:0] rx_r [$];
    logic [31:0] st [2];
    int          clk_err;

    note_dac_driver #(.CLK_FREQ(100_000_000)) dut (
        .clk(clk),
        .reset(reset),
        .left_freq(left_freq),
        .right_freq(right_freq),
        .volume(volume),
`ifdef NOTE_DAC_MUTE_EN
        .mute(mute),
`endif
        .mclk(mclk),
        .lrck(lrck),
        .sck(sck),
        .sdin(sdin)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] smp_of(input longint f, input longint acc_s, input logic [2:0] v);
        longint a;
        a = longint'(512) << (v > 3'd5 ? 3'd5 : v);
        if (f == 0 || 2 * f >= CLK) return 16'h0000;
        if ((acc_s / CLK) % 2 == 1) return a[15:0];
        return 16'(-a);
    endfunction

    // reference model: tone phase is the running total of 2*freq; sq is the parity of whole periods
    always @(posedge clk or negedge reset) begin
        longint f [2];
        logic   m;
        f[0] = longint'(left_freq);
        f[1] = longint'(right_freq);
`ifdef NOTE_DAC_MUTE_EN
        m = mute;
`else
        m = 1'b0;
`endif
        if (!reset) begin
            mcnt = '0;
            s[0] = 0;
            s[1] = 0;
            exp_q.delete();
            exp_q.push_back(32'h0);
        end else begin
            if (mcnt == 10'd1023)
                exp_q.push_back(m ? 32'h0 : {smp_of(f[0], s[0], volume), smp_of(f[1], s[1], volume)});
            for (int c = 0; c < 2; c++)
                s[c] = (f[c] == 0 || 2 * f[c] >= CLK) ? 0 : s[c] + 2 * f[c];
            mcnt = mcnt + 10'd1;
        end
    end

    // monitor: check clock pins, collect one bit per sck slot, compare each finished frame
    always @(negedge clk) begin
        logic [31:0] e;
        if (!reset) begin
            st[0] = '0;
            st[1] = '0;
            clk_err = 0;
            rx_l.delete();
            rx_r.delete();
        end else begin
            if ({mclk, sck, lrck} !== {mcnt[1], mcnt[3], mcnt[9]}) clk_err++;
            if (mcnt[3:0] == 4'd8) st[mcnt[9]] = {st[mcnt[9]][30:0], sdin};
            if (mcnt == 10'd1023) begin
                chk("clock_pins", clk_err, 0);
                clk_err = 0;
                chk("exp_queue_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("left_word", st[0], {1'b0, e[31:16], 15'b0});
                    chk("right_word", st[1], {1'b0, e[15:0], 15'b0});
                end
                rx_l.push_back(st[0]);
                rx_r.push_back(st[1]);
                frames_total++;
            end
        end
    end

    task automatic wait_rx(input int target);
        int n = 0;
        while (rx_l.size() < target && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("frame_timeout", rx_l.size() >= target, 1);
    endtask

    task automatic rand_freq(output logic [31:0] f);
        case ($urandom_range(0, 3))
            0: f = 32'd0;
            1: f = 32'($urandom_range(20_000, 2_000_000));
            2: f = 32'($urandom_range(49_999_990, 50_000_002));
            default: f = $urandom;
        endcase
    endtask

    initial begin
        int n;
        reset = 1'b0;
        left_freq = '0;
        right_freq = '0;
        volume = '0;
`ifdef NOTE_DAC_MUTE_EN
        mute = 1'b0;
`endif
        repeat (5) @(negedge clk);
        chk("reset_outputs_early", {mclk, sck, lrck, sdin}, 0);
        repeat (15) @(negedge clk);
        chk("reset_outputs_late", {mclk, sck, lrck, sdin}, 0);
        left_freq = 32'd440;
        volume = 3'd7;
        #2 reset = 1'b1;
        n = 0;
        while (!lrck && n < 2000) begin
            @(posedge clk);
            #1 n++;
        end
        chk("first_lrck_rise", n, 512);
        wait_rx(2);
        chk("first_frame_left_zero", rx_l[0], 32'h0);
        chk("first_left_word_c000", rx_l[1], 32'h6000_0000);
        left_freq = '0;
        right_freq = 32'd440;
        volume = 3'd3;
        wait_rx(rx_l.size() + 3);
        chk("silent_left", rx_l[$], 32'h0);
        chk("tone_right_f000", rx_r[$], 32'h7800_0000);
        left_freq = 32'd50_000_000;
        right_freq = 32'd49_999_999;
        volume = 3'd5;
        wait_rx(rx_l.size() + 2);
        chk("invalid_left_silent", rx_l[$], 32'h0);
        left_freq = 32'd1000;
        right_freq = 32'hFFFF_FFFF;
        wait_rx(rx_l.size() + 2);
        chk("valid_left_nonzero", rx_l[$] != 32'h0, 1);
        chk("overflow_right_silent", rx_r[$], 32'h0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (mcnt != 10'd700 && n < 2000);
        #2 reset = 1'b0;
        #1 chk("midframe_reset_outputs", {mclk, sck, lrck, sdin}, 0);
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        wait_rx(1);
        chk("post_reset_left_zero", rx_l[0], 32'h0);
        chk("post_reset_right_zero", rx_r[0], 32'h0);
        repeat (40) begin
            repeat ($urandom_range(100, 1500)) @(negedge clk);
            rand_freq(left_freq);
            rand_freq(right_freq);
            volume = 3'($urandom_range(0, 7));
`ifdef NOTE_DAC_MUTE_EN
            mute = $urandom_range(0, 3) == 0;
`endif
        end
        wait_rx(rx_l.size() + 2);
        chk("frames_checked", frames_total >= 20, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
